// File: rtl/seq_num_gen_l3_if.sv
// seq_num_gen_l3_if: bundles the allocation handshake, commit and squash
// notifications, occupancy and debug state of the sequence number generator.
//
// Handshake semantics: alloc_val[i] offers alloc_seq_num lane i. The offer
// depends only on generator registers, so it never depends on alloc_rdy in
// the same cycle. A lane transfers when alloc_val[i] & alloc_rdy[i] and every
// lower lane also transfers (prefix order). commit_val and squash_val are
// one-cycle notifications without backpressure.
//
// Modports:
//   master - the generator (drives offers, occupancy and debug state)
//   slave  - the fetch-side consumer (drives ready, commit and squash)
interface seq_num_gen_l3_if #(
  parameter int p_seq_num_bits = 5,
  parameter int p_alloc_width  = 2
);
  localparam int n_entries = 1 << p_seq_num_bits;

  logic [p_alloc_width*p_seq_num_bits-1:0] alloc_seq_num;
  logic [p_alloc_width-1:0]                alloc_val;
  logic [p_alloc_width-1:0]                alloc_rdy;
  logic                                    commit_val;
  logic [p_seq_num_bits-1:0]               commit_seq_num;
  logic                                    squash_val;
  logic [p_seq_num_bits-1:0]               squash_seq_num;
  logic [p_seq_num_bits:0]                 num_allocated;
  // Debug view of the pool state: oldest entry, next number, committed flags.
  logic [p_seq_num_bits-1:0]               dbg_head;
  logic [p_seq_num_bits-1:0]               dbg_tail;
  logic [n_entries-1:0]                    dbg_done;

  modport master (
    output alloc_seq_num, alloc_val, num_allocated, dbg_head, dbg_tail, dbg_done,
    input  alloc_rdy, commit_val, commit_seq_num, squash_val, squash_seq_num
  );

  modport slave (
    input  alloc_seq_num, alloc_val, num_allocated, dbg_head, dbg_tail, dbg_done,
    output alloc_rdy, commit_val, commit_seq_num, squash_val, squash_seq_num
  );
endinterface

// File: rtl/seq_num_gen_l3.sv
// seq_num_gen_l3: multi-lane in-order sequence number allocator.
//
// Hands out up to p_alloc_width consecutive numbers per cycle from a circular
// pool of 2**p_seq_num_bits numbers. Commits may arrive out of order; up to
// p_reclaim_width contiguous committed numbers are freed per cycle from the
// oldest end. A squash rewinds allocation to just after squash_seq_num.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - seq_num_gen_l3_if.master
//            alloc_seq_num/alloc_val/alloc_rdy : allocation lanes
//            commit_val/commit_seq_num         : commit notification
//            squash_val/squash_seq_num         : squash (oldest survivor)
//            num_allocated                     : current occupancy
//            dbg_head/dbg_tail/dbg_done        : internal state view
module seq_num_gen_l3 #(
  parameter int p_seq_num_bits  = 5,
  parameter int p_reclaim_width = 2,
  parameter int p_alloc_width   = 2
) (
  input logic             clk,
  input logic             rst,
  seq_num_gen_l3_if.master bus
);

  localparam int n_entries = 1 << p_seq_num_bits;
  localparam int cnt_w     = p_seq_num_bits + 1;

  typedef logic [p_seq_num_bits-1:0] seq_t;
  typedef logic [cnt_w-1:0]          cnt_t;

  seq_t                 head_q;
  seq_t                 tail_q;
  cnt_t                 count_q;
  logic [n_entries-1:0] done_q;

  cnt_t                                    free_c;
  logic [p_alloc_width-1:0]                alloc_val_c;
  logic [p_alloc_width*p_seq_num_bits-1:0] lanes_c;
  logic [p_alloc_width-1:0]                fire_c;
  cnt_t                                    n_alloc_c;
  cnt_t                                    n_free_c;
  cnt_t                                    n_free_eff_c;
  seq_t                                    sq_dist_c;
  seq_t                                    cm_dist_c;
  cnt_t                                    sq_keep_c;
  logic                                    squash_ok_c;
  logic                                    commit_ok_c;
  logic [n_entries-1:0]                    done_d;

  // Offers come from registers only.
  always_comb begin
    free_c      = cnt_t'(n_entries) - count_q;
    alloc_val_c = '0;
    lanes_c     = '0;
    for (int i = 0; i < p_alloc_width; i++) begin
      alloc_val_c[i]                         = free_c > cnt_t'(i);
      lanes_c[i*p_seq_num_bits +: p_seq_num_bits] = tail_q + seq_t'(i);
    end
  end

  // Prefix firing: a lane only transfers if every lower lane transfers.
  always_comb begin
    logic chain;
    chain     = 1'b1;
    fire_c    = '0;
    n_alloc_c = '0;
    for (int i = 0; i < p_alloc_width; i++) begin
      chain     = chain & alloc_val_c[i] & bus.alloc_rdy[i];
      fire_c[i] = chain;
      n_alloc_c = n_alloc_c + cnt_t'(fire_c[i]);
    end
  end

  // Length of the committed run at head, from registered done bits only.
  always_comb begin
    logic run;
    run      = 1'b1;
    n_free_c = '0;
    for (int k = 0; k < p_reclaim_width; k++) begin
      run = run & (cnt_t'(k) < count_q) & done_q[head_q + seq_t'(k)];
      if (run) n_free_c = n_free_c + cnt_t'(1);
    end
  end

  // Squash / commit legality is judged by distance from head, which is
  // unambiguous across pointer wrap because count separates full from empty.
  always_comb begin
    sq_dist_c   = bus.squash_seq_num - head_q;
    cm_dist_c   = bus.commit_seq_num - head_q;
    sq_keep_c   = {1'b0, sq_dist_c} + cnt_t'(1);
    squash_ok_c = bus.squash_val && ({1'b0, sq_dist_c} < count_q);
    commit_ok_c = bus.commit_val && ({1'b0, cm_dist_c} < count_q) &&
                  (!squash_ok_c || (cm_dist_c <= sq_dist_c));
    // Reclaim never eats past the surviving region of a squash.
    if (squash_ok_c && (n_free_c > sq_keep_c)) n_free_eff_c = sq_keep_c;
    else                                         n_free_eff_c = n_free_c;
  end

  // Per-entry done update: freed, squashed and newly allocated entries clear;
  // a legal commit sets.
  always_comb begin
    done_d = done_q;
    for (int j = 0; j < n_entries; j++) begin
      if ({1'b0, seq_t'(j) - head_q} < n_free_eff_c)
        done_d[j] = 1'b0;
      else if (squash_ok_c && ((seq_t'(j) - head_q) > sq_dist_c))
        done_d[j] = 1'b0;
      else if (!squash_ok_c && ({1'b0, seq_t'(j) - tail_q} < n_alloc_c))
        done_d[j] = 1'b0;
      else if (commit_ok_c && (seq_t'(j) == bus.commit_seq_num))
        done_d[j] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
    end else begin
      head_q <= head_q + seq_t'(n_free_eff_c);
      done_q <= done_d;
      if (squash_ok_c) begin
        // Any handshake firing this cycle is discarded by the consumer.
        tail_q  <= bus.squash_seq_num + seq_t'(1);
        count_q <= sq_keep_c - n_free_eff_c;
      end else begin
        tail_q  <= tail_q + seq_t'(n_alloc_c);
        count_q <= count_q + n_alloc_c - n_free_eff_c;
      end
    end
  end

  assign bus.alloc_val     = alloc_val_c;
  assign bus.alloc_seq_num = lanes_c;
  assign bus.num_allocated = count_q;
  assign bus.dbg_head      = head_q;
  assign bus.dbg_tail      = tail_q;
  assign bus.dbg_done      = done_q;

endmodule

// File: tb/tb_seq_num_gen_l3.sv
// tb_seq_num_gen_l3: bench for seq_num_gen_l3. A small instance (5/2/2) is
// exercised with directed scenarios; a large instance (8/4/4) runs a random
// soak against a queue-based reference model.
module tb_seq_num_gen_l3;

  logic clk = 1'b0;
  logic rst_s = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  seq_num_gen_l3_if #(.p_seq_num_bits(5), .p_alloc_width(2)) s_if ();
  seq_num_gen_l3_if #(.p_seq_num_bits(8), .p_alloc_width(4)) b_if ();

  seq_num_gen_l3 #(.p_seq_num_bits(5), .p_reclaim_width(2), .p_alloc_width(2))
    dut_s (.clk(clk), .rst(rst_s), .bus(s_if.master));
  seq_num_gen_l3 #(.p_seq_num_bits(8), .p_reclaim_width(4), .p_alloc_width(4))
    dut_b (.clk(clk), .rst(rst_b), .bus(b_if.master));

  // ---------------- small instance driver tasks ----------------
  task automatic drive_s(input logic [1:0] rdy, input logic cv, input logic [4:0] cs,
                         input logic sv, input logic [4:0] ss);
    s_if.alloc_rdy      = rdy;
    s_if.commit_val     = cv;
    s_if.commit_seq_num = cs;
    s_if.squash_val     = sv;
    s_if.squash_seq_num = ss;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_s(input logic [1:0] rdy);
    drive_s(rdy, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic reset_s();
    s_if.alloc_rdy  = '0;
    s_if.commit_val = 1'b0;
    s_if.squash_val = 1'b0;
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    rst_s = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    #1 rst_s = 1'b1;
    #1;
    n_checks++;
    if (s_if.num_allocated !== 6'd0) begin
      n_fail++; $display("FAIL reset_count_async: got %0d want 0", s_if.num_allocated);
    end
    @(posedge clk); #1;
    rst_s = 1'b0;
    #1;
    n_checks++;
    if (s_if.alloc_val !== 2'b11) begin
      n_fail++; $display("FAIL reset_val: got %b want 11", s_if.alloc_val);
    end
    n_checks++;
    if (s_if.alloc_seq_num !== {5'd1, 5'd0}) begin
      n_fail++; $display("FAIL reset_lanes: got %h want %h", s_if.alloc_seq_num, {5'd1, 5'd0});
    end
  endtask

  task automatic test_fill();
    logic [9:0] exp_l;
    for (int k = 0; k < 16; k++) begin
      exp_l = {5'(2*k+1), 5'(2*k)};
      n_checks++;
      if (s_if.alloc_seq_num !== exp_l || s_if.alloc_val !== 2'b11) begin
        n_fail++; $display("FAIL fill_offer_%0d: got val %b lanes %h want val 11 lanes %h",
                           k, s_if.alloc_val, s_if.alloc_seq_num, exp_l);
      end
      idle_s(2'b11);
    end
    n_checks++;
    if (s_if.num_allocated !== 6'd32) begin
      n_fail++; $display("FAIL fill_count: got %0d want 32", s_if.num_allocated);
    end
    n_checks++;
    if (s_if.alloc_val !== 2'b00) begin
      n_fail++; $display("FAIL fill_full_val: got %b want 00", s_if.alloc_val);
    end
  endtask

  task automatic test_ooo_reclaim();
    logic [4:0] cm [4] = '{5'd3, 5'd2, 5'd1, 5'd0};
    reset_s();
    idle_s(2'b11);
    idle_s(2'b11);
    for (int i = 0; i < 4; i++) begin
      drive_s(2'b00, 1'b1, cm[i], 1'b0, 5'd0);
      n_checks++;
      if (s_if.num_allocated !== 6'd4) begin
        n_fail++; $display("FAIL ooo_hold_%0d: got %0d want 4", i, s_if.num_allocated);
      end
    end
    idle_s(2'b00);
    n_checks++;
    if (s_if.num_allocated !== 6'd2 || s_if.dbg_head !== 5'd2) begin
      n_fail++; $display("FAIL ooo_free01: got count %0d head %0d want 2 2",
                         s_if.num_allocated, s_if.dbg_head);
    end
    idle_s(2'b00);
    n_checks++;
    if (s_if.num_allocated !== 6'd0 || s_if.dbg_head !== 5'd4) begin
      n_fail++; $display("FAIL ooo_free23: got count %0d head %0d want 0 4",
                         s_if.num_allocated, s_if.dbg_head);
    end
    n_checks++;
    if (s_if.alloc_seq_num !== {5'd5, 5'd4}) begin
      n_fail++; $display("FAIL ooo_next_offer: got %h want %h", s_if.alloc_seq_num, {5'd5, 5'd4});
    end
  endtask

  // Continues from head=tail=4, empty pool.
  task automatic test_full_wrap();
    logic [5:0] exp_c;
    repeat (16) idle_s(2'b11);
    n_checks++;
    if (s_if.num_allocated !== 6'd32 || s_if.alloc_val !== 2'b00) begin
      n_fail++; $display("FAIL wrap_full: got count %0d val %b want 32 00",
                         s_if.num_allocated, s_if.alloc_val);
    end
    for (int k = 0; k < 32; k++) begin
      drive_s(2'b00, 1'b1, 5'((4 + k) % 32), 1'b0, 5'd0);
      exp_c = (k == 0) ? 6'd32 : 6'(32 - k);
      n_checks++;
      if (s_if.num_allocated !== exp_c) begin
        n_fail++; $display("FAIL drain_count_%0d: got %0d want %0d", k, s_if.num_allocated, exp_c);
      end
      if (k == 0 || k == 1) begin
        n_checks++;
        if (s_if.alloc_val !== ((k == 0) ? 2'b00 : 2'b01)) begin
          n_fail++; $display("FAIL drain_val_%0d: got %b want %b", k, s_if.alloc_val,
                             (k == 0) ? 2'b00 : 2'b01);
        end
      end
    end
    idle_s(2'b00);
    n_checks++;
    if (s_if.num_allocated !== 6'd0) begin
      n_fail++; $display("FAIL drain_empty: got %0d want 0", s_if.num_allocated);
    end
    repeat (13) idle_s(2'b11);
    idle_s(2'b01);
    n_checks++;
    if (s_if.num_allocated !== 6'd27 || s_if.dbg_tail !== 5'd31) begin
      n_fail++; $display("FAIL lane0_only: got count %0d tail %0d want 27 31",
                         s_if.num_allocated, s_if.dbg_tail);
    end
    idle_s(2'b10);
    n_checks++;
    if (s_if.num_allocated !== 6'd27 || s_if.dbg_tail !== 5'd31) begin
      n_fail++; $display("FAIL lane1_only_blocked: got count %0d tail %0d want 27 31",
                         s_if.num_allocated, s_if.dbg_tail);
    end
    n_checks++;
    if (s_if.alloc_seq_num !== {5'd0, 5'd31} || s_if.alloc_val !== 2'b11) begin
      n_fail++; $display("FAIL wrap_offer: got val %b lanes %h want 11 %h",
                         s_if.alloc_val, s_if.alloc_seq_num, {5'd0, 5'd31});
    end
    idle_s(2'b11);
    n_checks++;
    if (s_if.num_allocated !== 6'd29 || s_if.alloc_seq_num !== {5'd2, 5'd1}) begin
      n_fail++; $display("FAIL wrap_after: got count %0d lanes %h want 29 %h",
                         s_if.num_allocated, s_if.alloc_seq_num, {5'd2, 5'd1});
    end
  endtask

  task automatic test_squash();
    reset_s();
    repeat (4) idle_s(2'b11);
    drive_s(2'b11, 1'b1, 5'd5, 1'b1, 5'd3);
    n_checks++;
    if (s_if.alloc_seq_num !== {5'd5, 5'd4} || s_if.num_allocated !== 6'd4) begin
      n_fail++; $display("FAIL squash_rewind: got lanes %h count %0d want %h 4",
                         s_if.alloc_seq_num, s_if.num_allocated, {5'd5, 5'd4});
    end
    n_checks++;
    if (s_if.dbg_tail !== 5'd4 || s_if.dbg_done[5] !== 1'b0) begin
      n_fail++; $display("FAIL squash_commit_drop: got tail %0d done5 %b want 4 0",
                         s_if.dbg_tail, s_if.dbg_done[5]);
    end
    drive_s(2'b00, 1'b1, 5'd1, 1'b1, 5'd2);
    n_checks++;
    if (s_if.num_allocated !== 6'd3 || s_if.dbg_tail !== 5'd3 || s_if.dbg_done !== 32'h2) begin
      n_fail++; $display("FAIL squash_commit_keep: got count %0d tail %0d done %h want 3 3 2",
                         s_if.num_allocated, s_if.dbg_tail, s_if.dbg_done);
    end
    drive_s(2'b00, 1'b1, 5'd0, 1'b0, 5'd0);
    idle_s(2'b00);
    n_checks++;
    if (s_if.num_allocated !== 6'd1 || s_if.dbg_head !== 5'd2) begin
      n_fail++; $display("FAIL squash_reclaim: got count %0d head %0d want 1 2",
                         s_if.num_allocated, s_if.dbg_head);
    end
    drive_s(2'b00, 1'b0, 5'd0, 1'b1, 5'd20);
    n_checks++;
    if (s_if.num_allocated !== 6'd1 || s_if.dbg_tail !== 5'd3) begin
      n_fail++; $display("FAIL squash_illegal: got count %0d tail %0d want 1 3",
                         s_if.num_allocated, s_if.dbg_tail);
    end
  endtask

  task automatic test_async_reset();
    reset_s();
    repeat (10) idle_s(2'b11);
    n_checks++;
    if (s_if.num_allocated !== 6'd20) begin
      n_fail++; $display("FAIL midfill_count: got %0d want 20", s_if.num_allocated);
    end
    s_if.alloc_rdy = 2'b00;
    #2 rst_s = 1'b1;
    #1;
    n_checks++;
    if (s_if.num_allocated !== 6'd0) begin
      n_fail++; $display("FAIL async_reset_now: got %0d want 0", s_if.num_allocated);
    end
    #1 rst_s = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (s_if.alloc_seq_num !== {5'd1, 5'd0} || s_if.alloc_val !== 2'b11) begin
      n_fail++; $display("FAIL async_reset_offer: got val %b lanes %h want 11 %h",
                         s_if.alloc_val, s_if.alloc_seq_num, {5'd1, 5'd0});
    end
  endtask

  // ---------------- reference model for the large instance ----------------
  typedef struct {
    int unsigned num;
    bit          done;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_tail;

  task automatic test_random_soak();
    int unsigned  size, nfree, na, nf, p, idx, hi;
    logic [3:0]   rdy;
    logic         cv, sv;
    logic [7:0]   cs, ss;
    logic [31:0]  exp_l;
    logic [3:0]   exp_v;
    logic [255:0] exp_d;
    bit           found;

    b_if.alloc_rdy = '0; b_if.commit_val = 1'b0; b_if.squash_val = 1'b0;
    b_if.commit_seq_num = '0; b_if.squash_seq_num = '0;
    rst_b = 1'b1;
    #2 rst_b = 1'b0;
    @(posedge clk); #1;
    mq.delete();
    m_tail = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      size  = mq.size();
      nfree = 256 - size;
      for (int i = 0; i < 4; i++) begin
        exp_v[i]         = nfree > i;
        exp_l[i*8 +: 8]  = 8'((m_tail + i) % 256);
      end
      exp_d = '0;
      foreach (mq[j]) if (mq[j].done) exp_d[mq[j].num] = 1'b1;

      n_checks++;
      if (b_if.alloc_val !== exp_v || b_if.alloc_seq_num !== exp_l) begin
        n_fail++; $display("FAIL soak_offer_c%0d: got val %b lanes %h want %b %h",
                           cyc, b_if.alloc_val, b_if.alloc_seq_num, exp_v, exp_l);
      end
      n_checks++;
      if (b_if.num_allocated !== 9'(size)) begin
        n_fail++; $display("FAIL soak_count_c%0d: got %0d want %0d", cyc, b_if.num_allocated, size);
      end
      n_checks++;
      if (b_if.dbg_head !== 8'((m_tail + 256 - size) % 256)) begin
        n_fail++; $display("FAIL soak_head_c%0d: got %0d want %0d", cyc, b_if.dbg_head,
                           (m_tail + 256 - size) % 256);
      end
      n_checks++;
      if (b_if.dbg_done !== exp_d) begin
        n_fail++; $display("FAIL soak_done_c%0d: got %h want %h", cyc, b_if.dbg_done, exp_d);
      end

      // Stimulus: alternate fill-biased and drain-biased phases.
      rdy = 4'($urandom_range(0, 15));
      cv  = (size > 0) && ($urandom_range(0, 99) < (((cyc / 500) % 2 == 1) ? 90 : 30));
      cs  = 8'($urandom_range(0, 255));
      if (cv) begin
        hi  = ($urandom_range(0, 3) == 0) ? size - 1 : ((size > 6) ? 5 : size - 1);
        idx = $urandom_range(0, hi);
        cs  = 8'(mq[idx].num);
      end
      sv = ($urandom_range(0, 59) == 0);
      ss = 8'($urandom_range(0, 255));
      if (sv && size > 0 && $urandom_range(0, 3) != 0) ss = 8'(mq[$urandom_range(0, size - 1)].num);

      // Model update from the pre-edge state.
      na = 0;
      for (int i = 0; i < 4; i++) begin
        if (nfree > i && rdy[i]) na++;
        else break;
      end
      nf = 0;
      for (int k = 0; k < 4; k++) begin
        if (k < size && mq[k].done) nf++;
        else break;
      end
      found = 1'b0; p = 0;
      if (sv) foreach (mq[j]) if (mq[j].num == ss) begin found = 1'b1; p = j; end
      if (found && nf > p + 1) nf = p + 1;
      if (cv) foreach (mq[j]) if (mq[j].num == cs && (!found || j <= p)) mq[j].done = 1'b1;
      if (found) begin
        while (mq.size() > p + 1) void'(mq.pop_back());
        m_tail = (ss + 1) % 256;
      end else begin
        for (int i = 0; i < na; i++) mq.push_back('{num: (m_tail + i) % 256, done: 1'b0});
        m_tail = (m_tail + na) % 256;
      end
      repeat (nf) void'(mq.pop_front());

      b_if.alloc_rdy      = rdy;
      b_if.commit_val     = cv;
      b_if.commit_seq_num = cs;
      b_if.squash_val     = sv;
      b_if.squash_seq_num = ss;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    s_if.alloc_rdy = '0; s_if.commit_val = 1'b0; s_if.commit_seq_num = '0;
    s_if.squash_val = 1'b0; s_if.squash_seq_num = '0;
    b_if.alloc_rdy = '0; b_if.commit_val = 1'b0; b_if.commit_seq_num = '0;
    b_if.squash_val = 1'b0; b_if.squash_seq_num = '0;
    test_reset();
    test_fill();
    test_ooo_reclaim();
    test_full_wrap();
    test_squash();
    test_async_reset();
    test_random_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
